// File: rtl/phase_timer.sv
// Down-counting phase timer: loads a preset, decrements once per TICK_DIV enabled clocks and
// pulses expired for one cycle on reaching zero. Define PHASE_TIMER_BCD_EN for BCD count outputs.
module phase_timer #(
    parameter int WIDTH    = 6,
    parameter int TICK_DIV = 50000000,
    parameter int DIV_W    = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] preset,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             busy,
`ifdef PHASE_TIMER_BCD_EN
    output logic             expired,
    output logic [3:0]       count_tens,
    output logic [3:0]       count_ones
`else
    output logic             expired
`endif
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [DIV_W-1:0] TickLast = DIV_W'(TICK_DIV - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [DIV_W-1:0] presc_q, presc_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            count_q <= '0;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            presc_q <= presc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        presc_d = presc_q;
        // A load is honoured in every state and always beats a pending tick.
        if (load) begin
            count_d = preset;
            presc_d = '0;
            state_d = (preset == '0) ? StDone : StRun;
        end else begin
            case (state_q)
                StRun: begin
                    if (enable) begin
                        if (presc_q == TickLast) begin
                            presc_d = '0;
                            if (count_q != '0) begin
                                count_d = count_q - WIDTH'(1);
                            end
                            if (count_q == WIDTH'(1)) begin
                                state_d = StDone;
                            end
                        end else begin
                            presc_d = presc_q + DIV_W'(1);
                        end
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = state_q;
            endcase
        end
    end

    assign count   = count_q;
    assign busy    = (state_q == StRun);
    assign expired = (state_q == StDone);

`ifdef PHASE_TIMER_BCD_EN
    logic [7:0] count8;
    assign count8     = 8'(count_q);
    assign count_tens = 4'(count8 / 8'd10);
    assign count_ones = 4'(count8 % 8'd10);
`endif

endmodule

// File: tb/tb_phase_timer.sv
// Self-checking bench for phase_timer with TICK_DIV=4; a cycle-level arithmetic model
// (elapsed enabled cycles since load) supplies every expected value.
module tb_phase_timer;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load = 1'b0;
    logic       enable = 1'b0;
    logic [5:0] preset = '0;
    logic [5:0] count;
    logic       busy;
    logic       expired;
`ifdef PHASE_TIMER_BCD_EN
    logic [3:0] count_tens;
    logic [3:0] count_ones;
`endif

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: phase length preset*TD enabled cycles, count = preset - elapsed/TD.
    bit m_run = 1'b0;
    bit m_pulse = 1'b0;
    int m_p = 0;
    int m_e = 0;
    int m_cnt = 0;

    phase_timer #(
        .WIDTH   (6),
        .TICK_DIV(TD),
        .DIV_W   (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .preset    (preset),
        .enable    (enable),
        .count     (count),
        .busy      (busy),
`ifdef PHASE_TIMER_BCD_EN
        .expired   (expired),
        .count_tens(count_tens),
        .count_ones(count_ones)
`else
        .expired   (expired)
`endif
    );

    always #5 clk = ~clk;

    task automatic step(input logic l, input logic [5:0] p, input logic en, input logic rn);
        load   = l;
        preset = p;
        enable = en;
        rst_n  = rn;
        @(posedge clk);
        if (!rn) begin
            m_run = 1'b0; m_pulse = 1'b0; m_cnt = 0;
        end else if (l) begin
            m_p = int'(p); m_e = 0; m_cnt = int'(p);
            m_run = (p != 0); m_pulse = (p == 0);
        end else if (m_run) begin
            if (en) m_e++;
            m_cnt = m_p - m_e / TD;
            if (m_e == m_p * TD) begin
                m_run = 1'b0; m_pulse = 1'b1;
            end
        end else begin
            m_pulse = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 6'd30, 1'b1, 1'b0);
            n_checks++;
            if ({busy, expired, count} !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_hold: busy=%b expired=%b count=%0d, want 0 0 0",
                         busy, expired, count);
            end
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 6'd30, 1'b1, 1'b1);
            n_checks++;
            if ({busy, expired, count} !== {m_run, m_pulse, 6'(m_cnt)}) begin
                n_fail++;
                $display("FAIL reset_idle: busy=%b expired=%b count=%0d, want %b %b %0d",
                         busy, expired, count, m_run, m_pulse, m_cnt);
            end
        end
    endtask

    task automatic test_countdown();
        int hit = -1;
        step(1'b1, 6'd5, 1'b1, 1'b1);
        n_checks++;
        if (count !== 6'd5 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL countdown_load: count=%0d busy=%b, want 5 1", count, busy);
        end
        for (int i = 1; i <= 30; i++) begin
            step(1'b0, 6'd0, 1'b1, 1'b1);
            n_checks++;
            if ({busy, expired, count} !== {m_run, m_pulse, 6'(m_cnt)}) begin
                n_fail++;
                $display("FAIL countdown_step%0d: busy=%b expired=%b count=%0d, want %b %b %0d",
                         i, busy, expired, count, m_run, m_pulse, m_cnt);
            end
            if (expired === 1'b1 && hit < 0) hit = i;
        end
        n_checks++;
        if (hit != 20) begin
            n_fail++;
            $display("FAIL countdown_expiry: expired after %0d cycles, want 20", hit);
        end
    endtask

    task automatic test_zero_b2b();
        step(1'b1, 6'd0, 1'b1, 1'b1);
        n_checks++;
        if ({busy, expired, count} !== {1'b0, 1'b1, 6'd0}) begin
            n_fail++;
            $display("FAIL zero_preset: busy=%b expired=%b count=%0d, want 0 1 0",
                     busy, expired, count);
        end
        step(1'b1, 6'd15, 1'b1, 1'b1);
        n_checks++;
        if ({busy, expired, count} !== {1'b1, 1'b0, 6'd15}) begin
            n_fail++;
            $display("FAIL b2b_load: busy=%b expired=%b count=%0d, want 1 0 15",
                     busy, expired, count);
        end
        for (int i = 1; i <= 62; i++) begin
            step(1'b0, 6'd0, 1'b1, 1'b1);
            n_checks++;
            if ({busy, expired, count} !== {m_run, m_pulse, 6'(m_cnt)}) begin
                n_fail++;
                $display("FAIL b2b_step%0d: busy=%b expired=%b count=%0d, want %b %b %0d",
                         i, busy, expired, count, m_run, m_pulse, m_cnt);
            end
        end
    endtask

    task automatic test_pause();
        int hit = -1;
        step(1'b1, 6'd3, 1'b1, 1'b1);
        for (int i = 1; i <= 30; i++) begin
            step(1'b0, 6'd0, !(i > 5 && i <= 15), 1'b1);
            n_checks++;
            if ({busy, expired, count} !== {m_run, m_pulse, 6'(m_cnt)}) begin
                n_fail++;
                $display("FAIL pause_step%0d: busy=%b expired=%b count=%0d, want %b %b %0d",
                         i, busy, expired, count, m_run, m_pulse, m_cnt);
            end
            if (expired === 1'b1 && hit < 0) hit = i;
        end
        n_checks++;
        if (hit != 22) begin
            n_fail++;
            $display("FAIL pause_expiry: expired after %0d cycles, want 22", hit);
        end
    endtask

    task automatic test_reload();
        int hit = -1;
        bit reached = 1'b0;
        step(1'b1, 6'd5, 1'b1, 1'b1);
        for (int i = 0; i < 40 && !reached; i++) begin
            step(1'b0, 6'd0, 1'b1, 1'b1);
            if (m_cnt == 3) reached = 1'b1;
        end
        // Reload while paused must still take effect.
        step(1'b1, 6'd30, 1'b0, 1'b1);
        n_checks++;
        if (!reached || {busy, expired, count} !== {1'b1, 1'b0, 6'd30}) begin
            n_fail++;
            $display("FAIL reload_load: busy=%b expired=%b count=%0d, want 1 0 30",
                     busy, expired, count);
        end
        for (int i = 1; i <= 125; i++) begin
            step(1'b0, 6'd0, 1'b1, 1'b1);
            if (expired === 1'b1 && hit < 0) hit = i;
        end
        n_checks++;
        if (hit != 120) begin
            n_fail++;
            $display("FAIL reload_expiry: expired after %0d cycles, want 120", hit);
        end
    endtask

    task automatic test_reset_midrun_bcd();
        logic [5:0] vals [3] = '{6'd22, 6'd63, 6'd5};
        bit reached = 1'b0;
        step(1'b1, 6'd20, 1'b1, 1'b1);
        for (int i = 0; i < 60 && !reached; i++) begin
            step(1'b0, 6'd0, 1'b1, 1'b1);
            if (count === 6'd12) reached = 1'b1;
        end
        step(1'b0, 6'd0, 1'b1, 1'b0);
        n_checks++;
        if (!reached || {busy, expired, count} !== 8'h00) begin
            n_fail++;
            $display("FAIL midrun_reset: reached=%b busy=%b expired=%b count=%0d, want 1 0 0 0",
                     reached, busy, expired, count);
        end
`ifdef PHASE_TIMER_BCD_EN
        n_checks++;
        if ({count_tens, count_ones} !== 8'h00) begin
            n_fail++;
            $display("FAIL bcd_reset: tens=%0d ones=%0d, want 0 0", count_tens, count_ones);
        end
`endif
        for (int k = 0; k < 3; k++) begin
            step(1'b1, vals[k], 1'b1, 1'b1);
            n_checks++;
            if (count !== vals[k]) begin
                n_fail++;
                $display("FAIL bcd_load%0d: count=%0d, want %0d", k, count, vals[k]);
            end
`ifdef PHASE_TIMER_BCD_EN
            n_checks++;
            if (count_tens !== 4'(int'(vals[k]) / 10) || count_ones !== 4'(int'(vals[k]) % 10)) begin
                n_fail++;
                $display("FAIL bcd_value%0d: tens=%0d ones=%0d, want %0d %0d", k,
                         count_tens, count_ones, int'(vals[k]) / 10, int'(vals[k]) % 10);
            end
`endif
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 19) == 0, 6'($urandom_range(0, 6)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 99) != 0);
            n_checks++;
            if ({busy, expired, count} !== {m_run, m_pulse, 6'(m_cnt)}) begin
                n_fail++;
                $display("FAIL random_step%0d: busy=%b expired=%b count=%0d, want %b %b %0d",
                         i, busy, expired, count, m_run, m_pulse, m_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_zero_b2b();
        test_pause();
        test_reload();
        test_reset_midrun_bcd();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
